// File: rtl/turn_signal_sequencer.sv
// Sequential tail-lamp turn-signal / hazard controller with a thermometer sweep, a step prescaler and a dark gap.
// Optional brake overlay is compiled in when TURN_SEQ_BRAKE_EN is defined.
module turn_signal_sequencer #(
  parameter int N_LAMPS  = 3,
  parameter int TICK_DIV = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               LEFT,
  input  logic               RIGHT,
  input  logic               HAZ,
`ifdef TURN_SEQ_BRAKE_EN
  input  logic               BRAKE,
`endif
  output logic [N_LAMPS-1:0] L_lights,
  output logic [N_LAMPS-1:0] R_lights,
  output logic               busy
);

  localparam int IDX_W = $clog2(N_LAMPS + 1);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_LAMPS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LSEQ   = 3'd1,
    S_RSEQ   = 3'd2,
    S_HAZ_ON = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick;
  logic [N_LAMPS-1:0] thermo;
  logic [N_LAMPS-1:0] all_on;

  assign tick   = (cnt_q == CNT_LAST);
  assign all_on = '1;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= IDX_FIRST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        idx_d = IDX_FIRST;
        if (HAZ || (LEFT && RIGHT)) state_d = S_HAZ_ON;
        else if (LEFT)              state_d = S_LSEQ;
        else if (RIGHT)             state_d = S_RSEQ;
      end
      S_LSEQ, S_RSEQ: begin
        // A hazard request aborts the sweep immediately; the opposite side is ignored.
        if (HAZ) begin
          state_d = S_HAZ_ON;
        end else if (tick) begin
          if (idx_q < IDX_LAST) idx_d = idx_q + IDX_W'(1);
          else                  state_d = S_GAP;
        end
      end
      S_HAZ_ON: if (tick) state_d = S_GAP;
      S_GAP:    if (tick) state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        idx_d   = IDX_FIRST;
      end
    endcase
  end

  // Prescaler restarts on any state change so every phase lasts exactly TICK_DIV cycles.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if ((state_d == S_IDLE) || (state_d != state_q) || tick) cnt_d = '0;
  end

  always_comb begin
    thermo = '0;
    for (int i = 0; i < N_LAMPS; i++) thermo[i] = (IDX_W'(i) < idx_q);
  end

  always_comb begin
    L_lights = '0;
    R_lights = '0;
    case (state_q)
      S_LSEQ:   L_lights = thermo;
      S_RSEQ:   R_lights = thermo;
      S_HAZ_ON: begin
        L_lights = all_on;
        R_lights = all_on;
      end
      default: ;
    endcase
`ifdef TURN_SEQ_BRAKE_EN
    // Brake lights any side that is not sweeping, without touching the sequencer state.
    if (BRAKE) begin
      case (state_q)
        S_IDLE, S_GAP: begin
          L_lights = all_on;
          R_lights = all_on;
        end
        S_LSEQ:  R_lights = all_on;
        S_RSEQ:  L_lights = all_on;
        default: ;
      endcase
    end
`endif
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_turn_signal_sequencer.sv
// Directed self-checking bench: a 4-lamp / TICK_DIV=3 instance for sweeps, aborts and reset,
// plus a 3-lamp / TICK_DIV=1 instance for the held-request repeat pattern.
module tb_turn_signal_sequencer;
  localparam int NL = 4;
  localparam int TD = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, left, right, haz;
  logic [NL-1:0] l_lights, r_lights;
  logic          busy;
  logic          b_reset_n, b_left, b_right, b_haz;
  logic [2:0]    b_l, b_r;
  logic          b_busy;
`ifdef TURN_SEQ_BRAKE_EN
  logic          brake, b_brake;
`endif

  int checks   = 0;
  int failures = 0;

  turn_signal_sequencer #(.N_LAMPS(NL), .TICK_DIV(TD)) dut (
    .clk(clk), .reset_n(reset_n), .LEFT(left), .RIGHT(right), .HAZ(haz),
`ifdef TURN_SEQ_BRAKE_EN
    .BRAKE(brake),
`endif
    .L_lights(l_lights), .R_lights(r_lights), .busy(busy)
  );

  turn_signal_sequencer #(.N_LAMPS(3), .TICK_DIV(1)) dut_b (
    .clk(clk), .reset_n(b_reset_n), .LEFT(b_left), .RIGHT(b_right), .HAZ(b_haz),
`ifdef TURN_SEQ_BRAKE_EN
    .BRAKE(b_brake),
`endif
    .L_lights(b_l), .R_lights(b_r), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [15:0] exp_l,
                           input logic [15:0] exp_r, input logic exp_busy);
    check({tag, ".L"}, 16'(l_lights), exp_l);
    check({tag, ".R"}, 16'(r_lights), exp_r);
    check({tag, ".busy"}, 16'(busy), 16'(exp_busy));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check("idle_reached", 16'(busy), 16'h0);
  endtask

  function automatic logic [15:0] therm(input int n);
    return 16'((1 << n) - 1);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  logic [2:0] held_l    [5] = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b000};
  logic       held_busy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    reset_n = 1'b1; left = 1'b0; right = 1'b0; haz = 1'b0;
    b_reset_n = 1'b0; b_left = 1'b0; b_right = 1'b0; b_haz = 1'b0;
`ifdef TURN_SEQ_BRAKE_EN
    brake = 1'b0; b_brake = 1'b0;
`endif

    // Reset: asynchronous assertion, then release between edges.
    #2 reset_n = 1'b0;
    #1 check_out("reset_async", 16'h0, 16'h0, 1'b0);
    step();
    check_out("reset_held", 16'h0, 16'h0, 1'b0);
    #2 begin reset_n = 1'b1; b_reset_n = 1'b1; end
    step();
    check_out("idle_after_reset", 16'h0, 16'h0, 1'b0);

    // Left sweep from a one-cycle pulse; a RIGHT blip mid-sweep must be ignored.
    left = 1'b1;
    step();
    left = 1'b0;
    check_out("lsweep_c1", therm(1), 16'h0, 1'b1);
    for (int c = 2; c <= 16; c++) begin
      right = (c == 8);
      step();
      if (c <= 12)      check_out($sformatf("lsweep_c%0d", c), therm((c - 1) / 3 + 1), 16'h0, 1'b1);
      else if (c <= 15) check_out($sformatf("lsweep_gap_c%0d", c), 16'h0, 16'h0, 1'b1);
      else              check_out("lsweep_idle", 16'h0, 16'h0, 1'b0);
    end
    right = 1'b0;

    // Right sweep aborted by HAZ at cycle 5.
    right = 1'b1;
    step();
    right = 1'b0;
    check_out("rabort_c1", 16'h0, therm(1), 1'b1);
    for (int c = 2; c <= 5; c++) begin
      step();
      check_out($sformatf("rabort_c%0d", c), 16'h0, therm((c - 1) / 3 + 1), 1'b1);
    end
    haz = 1'b1;
    step();
    haz = 1'b0;
    check_out("rabort_haz_c6", 16'hF, 16'hF, 1'b1);
    for (int c = 7; c <= 12; c++) begin
      step();
      if (c <= 8)       check_out($sformatf("rabort_haz_c%0d", c), 16'hF, 16'hF, 1'b1);
      else if (c <= 11) check_out($sformatf("rabort_gap_c%0d", c), 16'h0, 16'h0, 1'b1);
      else              check_out("rabort_idle", 16'h0, 16'h0, 1'b0);
    end

    // Simultaneous LEFT+RIGHT gives hazard; a LEFT request during GAP is ignored.
    left = 1'b1; right = 1'b1;
    step();
    left = 1'b0; right = 1'b0;
    check_out("both_c1", 16'hF, 16'hF, 1'b1);
    step(); check_out("both_c2", 16'hF, 16'hF, 1'b1);
    step(); check_out("both_c3", 16'hF, 16'hF, 1'b1);
    step(); check_out("both_gap_c4", 16'h0, 16'h0, 1'b1);
    left = 1'b1;
    step(); check_out("both_gap_c5", 16'h0, 16'h0, 1'b1);
    left = 1'b0;
    step(); check_out("both_gap_c6", 16'h0, 16'h0, 1'b1);
    step(); check_out("both_idle", 16'h0, 16'h0, 1'b0);

    // Reset dropped between edges mid-sweep, then a clean restart.
    left = 1'b1;
    step();
    left = 1'b0;
    step(); step(); step();
    check_out("rst_pre_c4", therm(2), 16'h0, 1'b1);
    #3 reset_n = 1'b0;
    #1 check_out("rst_mid_async", 16'h0, 16'h0, 1'b0);
    step();
    check_out("rst_mid_held", 16'h0, 16'h0, 1'b0);
    reset_n = 1'b1;
    left = 1'b1;
    step();
    left = 1'b0;
    check_out("rst_restart", therm(1), 16'h0, 1'b1);
    wait_idle(40);

`ifdef TURN_SEQ_BRAKE_EN
    // Brake overlay: non-sweeping side lit during LSEQ idx=2, both sides lit in IDLE.
    left = 1'b1;
    step();
    left = 1'b0;
    step(); step(); step();
    brake = 1'b1;
    #1 check_out("brake_lseq", therm(2), 16'hF, 1'b1);
    brake = 1'b0;
    wait_idle(40);
    brake = 1'b1;
    #1 check_out("brake_idle", 16'hF, 16'hF, 1'b0);
    brake = 1'b0;
    #1 check_out("brake_release", 16'h0, 16'h0, 1'b0);
`endif

    // Held LEFT on the 3-lamp, one-step-per-clock instance repeats every five cycles.
    b_left = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      check($sformatf("held_c%0d.L", c), 16'(b_l), 16'(held_l[(c - 1) % 5]));
      check($sformatf("held_c%0d.R", c), 16'(b_r), 16'h0);
      check($sformatf("held_c%0d.busy", c), 16'(b_busy), 16'(held_busy[(c - 1) % 5]));
    end
    b_left = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
